// File: rtl/pipelined_group_adder_if.sv
// Operand/result bus of the pipelined group adder.
// Upstream side: in_valid/in_ready handshake carrying x, y, carry_in, subtract.
// Downstream side: out_valid/out_ready handshake carrying z, carry_out, overflow.
// slave  : the adder's view (consumes operands, produces results).
// master : the environment's view (produces operands, consumes results).
interface pipelined_group_adder_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             carry_in;
    logic             subtract;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             carry_out;
    logic             overflow;

    modport slave (
        input  in_valid, x, y, carry_in, subtract, out_ready,
        output in_ready, out_valid, z, carry_out, overflow
    );

    modport master (
        output in_valid, x, y, carry_in, subtract, out_ready,
        input  in_ready, out_valid, z, carry_out, overflow
    );

endinterface

// File: rtl/pipelined_group_adder.sv
// Fully pipelined group ripple-carry adder/subtractor with valid/ready flow control.
// Stage k adds carry group k from its registered carry, so the carry ripples
// one group per clock. Latency is GROUP_COUNT cycles, throughput one per clock.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears all valid bits and result outputs
//   bus    - slave modport: in_valid/in_ready, x, y, carry_in, subtract,
//            out_valid/out_ready, z, carry_out, overflow
// in_ready is the only combinational output and depends on out_ready alone.
module pipelined_group_adder #(
    parameter int unsigned GROUP_COUNT = 2,
    parameter int unsigned GROUP_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    pipelined_group_adder_if.slave bus
);

    localparam int unsigned GC        = GROUP_COUNT;
    localparam int unsigned GW        = GROUP_WIDTH;
    localparam int unsigned GW1       = GW + 1;
    localparam int unsigned WIDTH     = GC * GW;
    localparam int unsigned TOP_SHIFT = WIDTH - GW;
    // Operand skew registers exist only between stages; keep one for GC=1.
    localparam int unsigned OPS       = (GC > 1) ? GC - 1 : 1;

    // Per-stage output registers and their next-state values.
    logic             valid_q [GC];
    logic             valid_d [GC];
    logic             carry_q [GC];
    logic             carry_d [GC];
    logic [WIDTH-1:0] sum_q   [GC];
    logic [WIDTH-1:0] sum_d   [GC];
    logic [WIDTH-1:0] x_q     [OPS];
    logic [WIDTH-1:0] x_d     [OPS];
    logic [WIDTH-1:0] yy_q    [OPS];
    logic [WIDTH-1:0] yy_d    [OPS];
    logic             ovf_q;
    logic             ovf_d;

    // Per-stage inputs: stage 0 from the bus, stage k from stage k-1 registers.
    logic             v_in    [GC];
    logic             c_in    [GC];
    logic [WIDTH-1:0] x_in    [GC];
    logic [WIDTH-1:0] yy_in   [GC];
    logic [WIDTH-1:0] s_in    [GC];
    logic [GW:0]      grp_c   [GC];

    logic             stall_c;

    // Stage datapath: one group add per stage, operands shift down one group.
    always_comb begin
        stall_c  = valid_q[GC-1] & ~bus.out_ready;

        // Subtract folds into the adder as x + ~y + 1 (carry_in inverted).
        x_in[0]  = bus.x;
        yy_in[0] = bus.y ^ {WIDTH{bus.subtract}};
        c_in[0]  = bus.carry_in ^ bus.subtract;
        v_in[0]  = bus.in_valid;
        s_in[0]  = '0;
        for (int k = 1; k < int'(GC); k++) begin
            x_in[k]  = x_q[k-1];
            yy_in[k] = yy_q[k-1];
            c_in[k]  = carry_q[k-1];
            v_in[k]  = valid_q[k-1];
            s_in[k]  = sum_q[k-1];
        end

        for (int k = 0; k < int'(OPS); k++) begin
            x_d[k]  = '0;
            yy_d[k] = '0;
        end

        for (int k = 0; k < int'(GC); k++) begin
            grp_c[k]   = {1'b0, GW'(x_in[k])} + {1'b0, GW'(yy_in[k])} + GW1'(c_in[k]);
            carry_d[k] = grp_c[k][GW];
            valid_d[k] = v_in[k];
            // New group enters at the top; after GC stages group 0 sits at bit 0.
            sum_d[k]   = (s_in[k] >> GW) | (WIDTH'(grp_c[k][GW-1:0]) << TOP_SHIFT);
        end

        for (int k = 0; k < int'(GC) - 1; k++) begin
            x_d[k]  = x_in[k] >> GW;
            yy_d[k] = yy_in[k] >> GW;
        end

        // Carry into the MSB is recovered as sum_msb ^ x_msb ^ y_msb.
        ovf_d = grp_c[GC-1][GW] ^ grp_c[GC-1][GW-1]
              ^ x_in[GC-1][GW-1] ^ yy_in[GC-1][GW-1];
    end

    // Pipeline registers: whole pipe freezes while the output is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(GC); k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
            end
            for (int k = 0; k < int'(OPS); k++) begin
                x_q[k]  <= '0;
                yy_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall_c) begin
            for (int k = 0; k < int'(GC); k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
            end
            for (int k = 0; k < int'(OPS); k++) begin
                x_q[k]  <= x_d[k];
                yy_q[k] <= yy_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = ~stall_c;
    assign bus.out_valid = valid_q[GC-1];
    assign bus.z         = sum_q[GC-1];
    assign bus.carry_out = carry_q[GC-1];
    assign bus.overflow  = ovf_q;

endmodule

// File: doc/pipelined_group_adder.md
Name: pipelined_group_adder

Overview:
- Parametrised, fully pipelined successor to the group ripple-carry adder.
- Each carry group gets its own register stage, so the carry ripples one group per clock instead of through the whole word in one cycle. This raises Fmax for wide operands.
- Adds a per-transaction add/subtract mode, a signed-overflow flag, and valid/ready flow control with backpressure.
- Sits between the operand registers (fed from switches/keys) and the result LED registers in the lab top level. It is also reusable as a datapath adder.

Parameters:
GROUP_COUNT, 2, number of carry groups = number of pipeline stages (>=1)
GROUP_WIDTH, 4, bits per group (>=1)
WIDTH, GROUP_COUNT*GROUP_WIDTH, operand/result width (derived; never overridden)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set present
in_ready  output  1  block can accept operands this cycle
x  input  WIDTH  operand A
y  input  WIDTH  operand B
carry_in  input  1  carry into bit 0
subtract  input  1  1 = x - y (+ carry_in semantics below), 0 = x + y
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
z  output  WIDTH  sum/difference
carry_out  output  1  carry out of MSB (in subtract mode: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Operand transform at input: yy = y ^ {WIDTH{subtract}}; cin = carry_in ^ subtract. Result = x + yy + cin, modulo 2^WIDTH.
- Stall = out_valid & ~out_ready. in_ready = ~stall (combinational). When stall is 1, every pipeline register, including the valid bits, holds.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Stage k (k = 0..GROUP_COUNT-1) computes group k bits [k*GW +: GW] from its registered carry. It registers:
  - the partial sum bits done so far;
  - the carry out of group k;
  - the not-yet-used upper operand groups (skew);
  - a valid bit.
- The last stage also registers the carry into the MSB, used for overflow.
- Latency: an operand accepted at edge t with no stalls appears with out_valid=1 after edge t+GROUP_COUNT-1. That is GROUP_COUNT register stages; stage 0 registers on the accepting edge.
- Throughput: one result per clock when out_ready=1 continuously.
- Bubbles (in_valid=0) propagate as valid=0. Output data under out_valid=0 is don't-care but must be stable while stalled.
- overflow = carry_into_MSB ^ carry_out of the final group, computed in the last stage.
- GROUP_COUNT=1 degenerates to a single registered adder with latency 1.
- Reset, when asserted, takes effect at the next edge regardless of stall or in_valid:
  - all valid bits = 0;
  - z = 0, carry_out = 0, overflow = 0;
  - in-flight transactions are discarded (never emitted).
- in_ready is 1 in the cycle after reset because out_valid=0.
- Simultaneous in-transfer and out-transfer in the same cycle is legal and required for full throughput.
- No combinational path from x/y/in_valid to any output. The only combinational path is out_ready -> in_ready.

Test Plan (GROUP_COUNT=2, GROUP_WIDTH=4, WIDTH=8 unless noted):
1. x=8'hFF, y=8'h01, carry_in=0, subtract=0, out_ready=1 -> exactly 2 edges later: out_valid=1, z=8'h00, carry_out=1, overflow=0; out_valid=0 on the next cycle.
2. x=8'h7F, y=8'h01, add -> z=8'h80, carry_out=0, overflow=1. Then subtract x=8'h05, y=8'h07, carry_in=0 -> z=8'hFE, carry_out=0, overflow=0. Then subtract x=8'h80, y=8'h01 -> z=8'h7F, carry_out=1, overflow=1.
3. Back-to-back: four consecutive cycles of in_valid=1 with (x,y) = (1,1), (2,2), (3,3), (4,4), add -> four consecutive out_valid cycles with z = 2, 4, 6, 8 starting 2 edges after the first accept; in_ready stays 1.
4. Backpressure: stream as in 3, drive out_ready=0 for 3 cycles once the first result is valid:
   - in_ready=0 throughout the stall;
   - z/out_valid are held stable;
   - after release, the results resume in order with no loss or duplication.
5. Reset mid-operation: accept two transactions, assert reset for 1 cycle while both are in flight -> after that edge out_valid=0 and z=0, carry_out=0, overflow=0; neither result ever appears; a new transaction afterwards has normal 2-cycle latency.
6. Parameter sweep: GROUP_COUNT in {1,3,4}, GROUP_WIDTH in {1,2,4}, random operands/modes against a reference model:
   - latency always GROUP_COUNT;
   - z, carry_out and overflow match the reference model for all vectors.
